// File: rtl/adc_readout_scheduler.sv
// Round-robin burst scheduler: merges N_CH ADC driver streams into one registered AXI-Stream output.
// Define ADC_SCHED_HEADER_EN to prefix each burst with a header beat carrying channel and burst count.
module adc_readout_scheduler #(
  parameter int N_CH      = 16,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 64
) (
  input  logic                     pl_clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          enable_mask,
  input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]          s_axis_tvalid,
  output logic [N_CH-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [3:0]               m_axis_tuser,
  output logic                     busy
);

`ifdef ADC_SCHED_HEADER_EN
  typedef enum logic [1:0] {IDLE, ARB, HDR, BURST} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;
`endif

  state_t state, state_nxt;

  logic [3:0]        rr_ptr;
  logic [3:0]        grant;
  logic [11:0]       beat_cnt;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              last_p1;
  logic [3:0]        user_p1;

  logic              out_free;
  logic              accept;
  logic              beat_last;
  logic [N_CH-1:0]   rot;
  logic              arb_found;
  logic [4:0]        arb_off;
  logic [4:0]        arb_sum;
  logic [3:0]        arb_grant;
  logic [4:0]        rr_sum;
  logic [3:0]        rr_nxt;
  logic [DATA_W-1:0] sel_data;

  // Output register may take a new beat when empty or draining this cycle.
  assign out_free  = !vld_p1 || m_axis_tready;
  assign beat_last = (beat_cnt == 12'(BURST_LEN - 1));
  assign accept    = |(s_axis_tvalid & s_axis_tready);

  // Eligible channels rotated so that bit 0 corresponds to rr_ptr.
  assign rot = N_CH'({enable_mask & s_axis_tvalid, enable_mask & s_axis_tvalid} >> rr_ptr);

  always_comb begin
    arb_found = 1'b0;
    arb_off   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_found && rot[i]) begin
        arb_found = 1'b1;
        arb_off   = 5'(i);
      end
    end
    arb_sum   = 5'(rr_ptr) + arb_off;
    arb_grant = (arb_sum >= 5'(N_CH)) ? 4'(arb_sum - 5'(N_CH)) : 4'(arb_sum);
    rr_sum    = 5'(arb_grant) + 5'd1;
    rr_nxt    = (rr_sum == 5'(N_CH)) ? 4'd0 : 4'(rr_sum);
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == 4'(i)) sel_data = s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  assign s_axis_tready = (state == BURST && out_free) ? (N_CH'(1) << grant) : '0;

`ifdef ADC_SCHED_HEADER_EN
  logic [15:0]       burst_cnt;
  logic              hdr_load;
  logic [DATA_W-1:0] hdr_word;

  assign hdr_load = (state == HDR) && out_free;

  always_comb begin
    hdr_word        = '0;
    hdr_word[3:0]   = grant;
    hdr_word[31:16] = burst_cnt;
  end

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst)           burst_cnt <= '0;
    else if (hdr_load) burst_cnt <= burst_cnt + 16'd1;
  end
`endif

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (|enable_mask) state_nxt = ARB;
`ifdef ADC_SCHED_HEADER_EN
      ARB:   state_nxt = arb_found ? HDR : IDLE;
      HDR:   if (out_free) state_nxt = BURST;
`else
      ARB:   state_nxt = arb_found ? BURST : IDLE;
`endif
      BURST: if (accept && beat_last) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else if (state == ARB && arb_found) begin
      grant    <= arb_grant;
      rr_ptr   <= rr_nxt;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 12'd1;
    end
  end

  // ---- stage p1: output register, overwritten on accept even while draining ----
  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      user_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      last_p1 <= beat_last;
      user_p1 <= grant;
`ifdef ADC_SCHED_HEADER_EN
    end else if (hdr_load) begin
      vld_p1  <= 1'b1;
      data_p1 <= hdr_word;
      last_p1 <= 1'b0;
      user_p1 <= grant;
`endif
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tuser  = user_p1;

endmodule

// File: tb/tb_adc_readout_scheduler.sv
// Scoreboard bench for adc_readout_scheduler: per-channel sources with sequence-numbered data,
// expected beat order predicted from the round-robin burst rules and compared at the output.
module tb_adc_readout_scheduler;
  localparam int N_CH      = 16;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  logic                   pl_clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        enable_mask;
  logic [N_CH*DATA_W-1:0] s_axis_tdata;
  logic [N_CH-1:0]        s_axis_tvalid;
  logic [N_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]      m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic [3:0]             m_axis_tuser;
  logic                   busy;

  adc_readout_scheduler #(.N_CH(N_CH), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .pl_clk       (pl_clk),
    .rst          (rst),
    .enable_mask  (enable_mask),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .busy         (busy)
  );

  always #5 pl_clk = ~pl_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [36:0] expq[$];
  int          seq[N_CH];
  int          eseq[N_CH];
  int          left[N_CH];
  int          bcnt;
  int          gate_ch = -1;
  int          gate_after = 0;
  int          gate_cyc = 0;
  logic [3:0]  rdy_pat = 4'hF;
  int          cyc = 0;
  logic        stalled_prev = 1'b0;
  logic [36:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N_CH; i++) begin
      s_axis_tdata[i*DATA_W +: DATA_W] = {8'(i), 24'(seq[i])};
      s_axis_tvalid[i] = (left[i] > 0) &&
                         !(i == gate_ch && seq[i] == gate_after && gate_cyc > 0);
    end
    m_axis_tready = rdy_pat[cyc[1:0]];
  endtask

  task automatic push_hdr(input int ch);
`ifdef ADC_SCHED_HEADER_EN
    expq.push_back({4'(ch), 1'b0, 16'(bcnt), 12'd0, 4'(ch)});
    bcnt = (bcnt + 1) & 16'hFFFF;
`else
    if (ch < 0) bcnt = 0;
`endif
  endtask

  task automatic push_beat(input int ch, input int k);
    expq.push_back({4'(ch), (k == BURST_LEN - 1), 8'(ch), 24'(eseq[ch])});
    eseq[ch]++;
  endtask

  task automatic push_burst(input int ch);
    push_hdr(ch);
    for (int k = 0; k < BURST_LEN; k++) push_beat(ch, k);
  endtask

  // One clock: drive at negedge, check output handshake, then retire source handshakes after posedge.
  task automatic step();
    logic [N_CH-1:0] hs;
    logic            gated;
    logic [36:0]     obs;
    drive_src();
    #1;
    obs = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) begin
      if (expq.size() == 0) chk("extra_beat_vld", 64'(m_axis_tvalid), 64'd0);
      else chk("beat", 64'(obs), 64'(expq.pop_front()));
    end
    if (stalled_prev) chk("stall_hold", 64'(obs), 64'(held));
    stalled_prev = m_axis_tvalid && !m_axis_tready;
    if (stalled_prev) begin
      held = obs;
      chk("stall_srdy", 64'(s_axis_tready), 64'd0);
    end
    gated = gate_cyc > 0 && gate_ch >= 0 && seq[gate_ch] == gate_after;
    if (gated) chk("gap_busy", 64'(busy), 64'd1);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge pl_clk);
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (hs[i]) begin
        seq[i]++;
        left[i]--;
      end
    end
    if (gated) gate_cyc--;
    cyc++;
    @(negedge pl_clk);
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  task automatic restart_model();
    bcnt = 0;
    stalled_prev = 1'b0;
    cyc = 0;
    for (int i = 0; i < N_CH; i++) eseq[i] = seq[i];
    expq.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    enable_mask = '0;
    gate_ch = -1;
    gate_cyc = 0;
    rdy_pat = 4'hF;
    for (int i = 0; i < N_CH; i++) left[i] = 0;
    drive_src();
    repeat (2) @(negedge pl_clk);
    rst = 1'b0;
    restart_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    chk({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
    chk({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
    chk({tag, "_busy"},   64'(busy),          64'd0);
    chk({tag, "_srdy"},   64'(s_axis_tready), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      seq[i] = 0;
      left[i] = 0;
    end
    bcnt = 0;
    rst = 1'b1;
    enable_mask = '0;
    drive_src();
    #2;
    check_reset_outputs("rst");
    @(negedge pl_clk);
    reset_dut();

    // Two channels alternating bursts.
    enable_mask = 16'h0005;
    left[0] = 1000;
    left[2] = 1000;
    push_burst(0); push_burst(2); push_burst(0); push_burst(2);
    run_until_empty("alt_done", 300);

    // rr_ptr driven to 15, then wrap to channel 0.
    reset_dut();
    enable_mask = 16'h4000;
    left[14] = BURST_LEN;
    push_burst(14);
    run_until_empty("ch14_done", 100);
    enable_mask = 16'h8001;
    left[15] = BURST_LEN;
    push_burst(15);
    run_until_empty("ch15_done", 100);
    left[0] = BURST_LEN;
    left[15] = BURST_LEN;
    push_burst(0); push_burst(15);
    run_until_empty("wrap_done", 100);

    // Output backpressure pattern 1,0,0,1.
    reset_dut();
    enable_mask = 16'h0002;
    left[1] = 2 * BURST_LEN;
    rdy_pat = 4'b1001;
    push_burst(1); push_burst(1);
    run_until_empty("stall_done", 200);

    // Source valid gap at beat 2 of the burst; mask change mid-burst ignored.
    reset_dut();
    enable_mask = 16'h0002;
    left[1] = BURST_LEN;
    gate_ch = 1;
    gate_after = seq[1] + 2;
    gate_cyc = 10;
    push_burst(1);
    step(); step(); step();
    enable_mask = 16'h0004;
    left[2] = 100;
    run_until_empty("gap_done", 100);
    chk("gap_len", 64'(gate_cyc), 64'd0);

    // Reset asserted after beat 3 of a burst.
    reset_dut();
    enable_mask = 16'h0005;
    left[0] = 1000;
    left[2] = 1000;
    push_hdr(0);
    for (int k = 0; k < 3; k++) push_beat(0, k);
    run_until_empty("pre_rst_done", 100);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge pl_clk);
    rst = 1'b0;
    restart_model();
    push_burst(0); push_burst(2);
    run_until_empty("post_rst_done", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
